image_mem_responder: RTL
========================

IMAGE_MEM_RESPONDER -- requirements
Module: image_mem_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning. The module SHALL implement each of the following.
  AW  16  internal word-address width; DEPTH = 2**AW words of 10 bits.
  LOAD_LEN  16384  words accepted from the host before a run; range 1..DEPTH.
  DUMP_BASE  16384  first word address streamed out after a run.
  DUMP_LEN  4096  words streamed out; DUMP_BASE+DUMP_LEN <= DEPTH.
REQ-002 Ports, one per line: name, direction, width, meaning. The module SHALL implement each of the following.
  clk  in  1  single clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  AddrsIn  in  20  word address from the processor core.
  MemW  in  10  write data from the core.
  RoW  in  1  1 = write, 0 = read.
  MemR  out  10  read data to the core.
  start  out  1  run enable to the core.
  flag  in  1  core finished (sticky high from the core).
  ld_valid  in  1  host load word valid.
  ld_data  in  10  host load word.
  ld_ready  out  1  responder accepts the load word.
  dump_valid  out  1  dump word valid.
  dump_data  out  10  dump word.
  dump_ready  in  1  host accepts the dump word.
  done  out  1  one-cycle pulse after the last dump word.
  oob_err  out  1  sticky flag: the core accessed AddrsIn[19:AW] != 0.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DUMP.
REQ-004 IDLE: the FSM SHALL go to LOAD when ld_valid=1; it SHALL accept no word in that cycle, and ld_ready SHALL be 0.
REQ-005 LOAD: ld_ready SHALL be 1; each cycle with ld_valid&ld_ready SHALL write ld_data to mem[ld_ptr] and increment ld_ptr, which starts at 0.
REQ-006 LOAD: the handshake of word LOAD_LEN-1 SHALL move the FSM to RUN on the same edge, and ld_ptr SHALL clear to 0.
REQ-007 RUN: start SHALL be 1 (registered) from the first RUN cycle; start SHALL be 0 in every other state.
REQ-008 RUN, RoW=0, in-range address: MemR SHALL equal mem[AddrsIn[AW-1:0]], registered with 1-cycle latency.
REQ-009 RUN, RoW=1, in-range address: MemW SHALL be written to mem[AddrsIn[AW-1:0]] at the edge; MemR SHALL hold its previous value.
REQ-010 Out-of-range address (AddrsIn[19:AW] != 0): a write SHALL be dropped, a read SHALL return 0, and oob_err SHALL set; oob_err clears only on reset.
REQ-011 The core port SHALL be ignored outside RUN; MemR SHALL hold its value there.
REQ-012 RUN: flag=1 SHALL move the FSM to DUMP at the next edge, and start SHALL drop in that same edge. A core write with RoW=1 in the same cycle as flag SHALL still be performed.
REQ-013 DUMP: dump words SHALL be read from DUMP_BASE .. DUMP_BASE+DUMP_LEN-1 in ascending order, with 1 prefetch cycle. dump_valid SHALL rise 1 cycle after DUMP entry.
REQ-014 DUMP: while dump_valid=1 and dump_ready=0, dump_data SHALL hold stable. With dump_ready held at 1, one word SHALL transfer per cycle (no bubbles).
REQ-015 DUMP: the handshake of the last word SHALL clear dump_valid, pulse done for 1 cycle, and return the FSM to IDLE.
REQ-016 ld_valid outside IDLE/LOAD SHALL be ignored, and ld_ready SHALL stay 0.
REQ-017 Memory SHALL be single-port synchronous; the host and core ports are never active in the same state, so no arbitration is required.

Reset
REQ-018 reset=0 SHALL asynchronously force the following: state=IDLE; start=0; ld_ready=0; dump_valid=0; done=0; oob_err=0; MemR=0; dump_data=0; all pointers=0.
REQ-019 Memory contents SHALL NOT be cleared by reset.
REQ-020 Reset asserted mid-LOAD, mid-RUN or mid-DUMP SHALL abort the operation. After deassertion the block SHALL restart from IDLE.

Verification
REQ-021 Load with LOAD_LEN=4: send 0x001..0x004 with ld_valid gaps. Required: exactly 4 accepts, start=1 on the cycle after the 4th accept, core reads of addresses 0..3 return 0x001..0x004 one cycle later.
REQ-022 RUN: core writes 0x3FF to address 5, then reads address 5. Required: MemR=0x3FF one cycle after the read address is presented; MemR unchanged during the write cycle.
REQ-023 RUN: core read at address 0x10000 (AW=16). Required: MemR=0, oob_err=1 and stays 1; a write there leaves mem[0] unchanged.
REQ-024 Dump with DUMP_LEN=3, dump_ready toggled 1,0,0,1,1. Required: 3 distinct words in address order, data stable while stalled, done pulses once, state=IDLE.
REQ-025 Assert reset in the 2nd DUMP cycle. Required: dump_valid=0 and start=0 immediately (asynchronous); a new load after release starts at ld_ptr=0.
REQ-026 flag and a core write (RoW=1) in the same RUN cycle. Required: the write lands in memory, and the dump of that address returns the written value.

Source files
------------

// File: rtl/image_mem_responder.sv
// -----------------------------------------------------------------------------
// image_mem_responder
//
// Memory responder placed between a host and an image-processing core.
// One 10-bit wide single-port synchronous RAM is shared by three phases:
//
//   IDLE -> LOAD : the host streams LOAD_LEN words into mem[0..LOAD_LEN-1]
//   LOAD -> RUN  : the core owns the RAM through AddrsIn/MemW/RoW/MemR
//   RUN  -> DUMP : once the core raises flag, DUMP_LEN words starting at
//                  DUMP_BASE are streamed back to the host
//   DUMP -> IDLE : after the last dump handshake, with a one-cycle done pulse
//
// Only one phase touches the RAM at a time, so a single address/write-data
// mux feeds the RAM and no arbitration is needed.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   AddrsIn     20-bit word address from the core (bits above AW must be 0)
//   MemW        core write data
//   RoW         core access type: 1 = write, 0 = read
//   MemR        core read data, one-cycle latency, holds between reads
//   start       run enable to the core, high for the whole RUN phase
//   flag        core finished (sticky from the core)
//   ld_valid    host load word valid
//   ld_data     host load word
//   ld_ready    responder accepts the load word (LOAD phase only)
//   dump_valid  dump word valid
//   dump_data   dump word
//   dump_ready  host accepts the dump word
//   done        one-cycle pulse after the last dump word
//   oob_err     sticky: the core presented an address outside the RAM
// -----------------------------------------------------------------------------
module image_mem_responder #(
    parameter int AW        = 16,     // word-address width, DEPTH = 2**AW (AW <= 20)
    parameter int LOAD_LEN  = 16384,  // words loaded before a run, 1..DEPTH
    parameter int DUMP_BASE = 16384,  // first dumped word address
    parameter int DUMP_LEN  = 4096    // dumped words, DUMP_BASE+DUMP_LEN <= DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] AddrsIn,
    input  logic [9:0]  MemW,
    input  logic        RoW,
    output logic [9:0]  MemR,
    output logic        start,
    input  logic        flag,
    input  logic        ld_valid,
    input  logic [9:0]  ld_data,
    output logic        ld_ready,
    output logic        dump_valid,
    output logic [9:0]  dump_data,
    input  logic        dump_ready,
    output logic        done,
    output logic        oob_err
);

    localparam int DEPTH = 2 ** AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DUMP = 2'd3;

    localparam logic [AW-1:0] LOAD_LAST  = AW'(LOAD_LEN - 1);
    localparam logic [AW-1:0] DUMP_FIRST = AW'(DUMP_BASE);
    localparam logic [AW:0]   DUMP_COUNT = (AW + 1)'(DUMP_LEN);

    logic [1:0]    state;
    logic [AW-1:0] ld_ptr;     // next load address
    logic [AW:0]   dump_ptr;   // number of dump words already fetched

    logic [9:0]    mem [DEPTH];

    logic          core_in_range;
    logic          core_wr;
    logic          core_rd;
    logic          ld_fire;
    logic          dump_fire;
    logic          dump_fetch;
    logic          dump_last;

    logic [AW-1:0] mem_addr;
    logic [9:0]    mem_wdata;
    logic          mem_we;

    // ------------------------------------------------------------------
    // Handshake and access decode
    // ------------------------------------------------------------------
    assign core_in_range = ((AddrsIn >> AW) == 20'd0);
    assign core_wr       = (state == S_RUN) &&  RoW && core_in_range;
    assign core_rd       = (state == S_RUN) && !RoW;

    assign ld_fire       = (state == S_LOAD) && ld_valid && ld_ready;
    assign dump_fire     = dump_valid && dump_ready;

    // A new dump word is fetched for the very first slot (output empty) or
    // whenever the current word leaves, which keeps the stream bubble-free.
    assign dump_fetch    = (state == S_DUMP) && (dump_ptr != DUMP_COUNT)
                           && (!dump_valid || dump_ready);
    assign dump_last     = (state == S_DUMP) && dump_fire
                           && (dump_ptr == DUMP_COUNT);

    // ------------------------------------------------------------------
    // Single RAM port: address and write data selected by phase
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        mem_addr  = ld_ptr;
        mem_wdata = ld_data;
        mem_we    = 1'b0;
        case (state)
            S_LOAD: begin
                mem_addr = ld_ptr;
                mem_we   = ld_fire;
            end
            S_RUN: begin
                mem_addr  = AddrsIn[AW-1:0];
                mem_wdata = MemW;
                mem_we    = core_wr;
            end
            S_DUMP: begin
                mem_addr = DUMP_FIRST + dump_ptr[AW-1:0];
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // NOTE: the RAM array has no reset; clearing it would prevent RAM
    // inference and its contents must survive a reset anyway.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and registered outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            ld_ptr     <= '0;
            dump_ptr   <= '0;
            start      <= 1'b0;
            ld_ready   <= 1'b0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
            done       <= 1'b0;
            oob_err    <= 1'b0;
            MemR       <= '0;
        end else begin
            done <= 1'b0;

            // Core reads: out-of-range addresses read back as zero. Writes
            // leave MemR untouched.
            if (core_rd) begin
                MemR <= core_in_range ? mem[mem_addr] : 10'd0;
            end

            if ((state == S_RUN) && !core_in_range) begin
                oob_err <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // The word presented here is not taken; ld_ready only
                    // rises once LOAD is entered.
                    if (ld_valid) begin
                        state    <= S_LOAD;
                        ld_ready <= 1'b1;
                        ld_ptr   <= '0;
                    end
                end

                S_LOAD: begin
                    if (ld_fire) begin
                        if (ld_ptr == LOAD_LAST) begin
                            state    <= S_RUN;
                            ld_ready <= 1'b0;
                            start    <= 1'b1;
                            ld_ptr   <= '0;
                        end else begin
                            ld_ptr <= ld_ptr + 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    // A write presented together with flag is still done by
                    // the RAM process above, since state is still RUN.
                    if (flag) begin
                        state    <= S_DUMP;
                        start    <= 1'b0;
                        dump_ptr <= '0;
                    end
                end

                S_DUMP: begin
                    if (dump_fetch) begin
                        dump_data  <= mem[mem_addr];
                        dump_valid <= 1'b1;
                        dump_ptr   <= dump_ptr + 1'b1;
                    end else if (dump_last) begin
                        dump_valid <= 1'b0;
                        dump_ptr   <= '0;
                        done       <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
